// File: rtl/panel_bus_ctrl.sv
// rtl/panel_bus_ctrl.sv - front-panel sequencer and memory-bus arbiter
//
// Purpose:
//   In RUN, passes the CPU bus through to the memory decode and forwards the
//   free-running CPU clock-enable. In PAUSE, owns the bus and runs EXAMINE,
//   EXAMINE NEXT, DEPOSIT, DEPOSIT NEXT and single-step as short fixed-length
//   sequences, showing the result on the panel LEDs.
//
// Configuration macro:
//   PANEL_READBACK_EN - deposits read the written location back (WR->RA->RD)
//                       and show the memory value; otherwise deposits are
//                       WR->IDLE and show the switch data.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   run_sw                      1 = RUN, 0 = PAUSE
//   cpu_ce_in / cpu_ce_o        free-running / gated CPU clock-enable
//   examine_i, examine_next_i,
//   deposit_i, deposit_next_i,
//   step_i                      one-cycle debounced pushbutton pulses
//   sw_addr, sw_data            address / data switches
//   cpu_addr, cpu_wdata,
//   cpu_we, cpu_rd              CPU bus
//   mem_addr, mem_wdata,
//   mem_we, mem_rd              muxed bus to memory decode
//   mem_rdata                   memory read data, 1-cycle latency
//   panel_addr, panel_data      LED values
//   busy                        panel sequence in progress
//   done                        one-cycle completion pulse

module panel_bus_ctrl #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run_sw,
   input  logic              cpu_ce_in,
   output logic              cpu_ce_o,
   input  logic              examine_i,
   input  logic              examine_next_i,
   input  logic              deposit_i,
   input  logic              deposit_next_i,
   input  logic              step_i,
   input  logic [ADDR_W-1:0] sw_addr,
   input  logic [DATA_W-1:0] sw_data,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_we,
   input  logic              cpu_rd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_rd,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] panel_addr,
   output logic [DATA_W-1:0] panel_data,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WR   = 2'd1,
      S_RA   = 2'd2,
      S_RD   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] fsm_addr_q, fsm_addr_d;
   logic [DATA_W-1:0] fsm_wdata_q, fsm_wdata_d;
   logic              fsm_we_q, fsm_we_d;
   logic              fsm_rd_q, fsm_rd_d;
   logic              cpu_owns_q, cpu_owns_d;
   logic              step_ce_q, step_ce_d;
   logic [ADDR_W-1:0] panel_addr_q, panel_addr_d;
   logic [DATA_W-1:0] panel_data_q, panel_data_d;
   logic              done_q, done_d;

   logic [ADDR_W-1:0] addr_inc;
   logic [ADDR_W-1:0] target;
   logic              go_wr;
   logic              go_ra;

   // Natural ADDR_W-bit wrap gives FFFF -> 0000 for the NEXT commands.
   assign addr_inc = panel_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         fsm_addr_q   <= '0;
         fsm_wdata_q  <= '0;
         fsm_we_q     <= 1'b0;
         fsm_rd_q     <= 1'b0;
         cpu_owns_q   <= 1'b0;
         step_ce_q    <= 1'b0;
         panel_addr_q <= '0;
         panel_data_q <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         fsm_addr_q   <= fsm_addr_d;
         fsm_wdata_q  <= fsm_wdata_d;
         fsm_we_q     <= fsm_we_d;
         fsm_rd_q     <= fsm_rd_d;
         cpu_owns_q   <= cpu_owns_d;
         step_ce_q    <= step_ce_d;
         panel_addr_q <= panel_addr_d;
         panel_data_q <= panel_data_d;
         done_q       <= done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      fsm_addr_d   = fsm_addr_q;
      fsm_wdata_d  = fsm_wdata_q;
      fsm_we_d     = 1'b0;
      fsm_rd_d     = 1'b0;
      step_ce_d    = 1'b0;
      panel_addr_d = panel_addr_q;
      panel_data_d = panel_data_q;
      done_d       = 1'b0;
      target       = panel_addr_q;
      go_wr        = 1'b0;
      go_ra        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (run_sw) begin
               // LEDs track the live CPU bus while running.
               panel_addr_d = cpu_addr;
               panel_data_d = mem_rdata;
            end else if (deposit_next_i) begin
               target = addr_inc;
               go_wr  = 1'b1;
            end else if (deposit_i) begin
               target = panel_addr_q;
               go_wr  = 1'b1;
            end else if (examine_next_i) begin
               target = addr_inc;
               go_ra  = 1'b1;
            end else if (examine_i) begin
               target = sw_addr;
               go_ra  = 1'b1;
            end else if (step_i) begin
               step_ce_d = 1'b1;
            end

            // The FSM bus outputs are loaded together with the state so
            // the first sequence cycle already presents the access.
            if (go_wr) begin
               state_d      = S_WR;
               fsm_addr_d   = target;
               fsm_wdata_d  = sw_data;
               fsm_we_d     = 1'b1;
               panel_addr_d = target;
            end else if (go_ra) begin
               state_d      = S_RA;
               fsm_addr_d   = target;
               fsm_rd_d     = 1'b1;
               panel_addr_d = target;
            end
         end

         S_WR: begin
`ifdef PANEL_READBACK_EN
            state_d  = S_RA;
            fsm_rd_d = 1'b1;
`else
            state_d      = S_IDLE;
            panel_data_d = fsm_wdata_q;
            done_d       = 1'b1;
`endif
         end

         S_RA: begin
            state_d = S_RD;
         end

         S_RD: begin
            panel_data_d = mem_rdata;
            done_d       = 1'b1;
            state_d      = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Registered copy of "idle next cycle"; it is also forced low by reset,
      // which keeps every output at zero while reset is held.
      cpu_owns_d = (state_d == S_IDLE);
   end

   // In PAUSE the CPU keeps the address mux but its strobes are masked so a
   // frozen CPU can never write memory.
   assign mem_addr   = cpu_owns_q ? cpu_addr            : fsm_addr_q;
   assign mem_wdata  = cpu_owns_q ? cpu_wdata           : fsm_wdata_q;
   assign mem_we     = cpu_owns_q ? (cpu_we & run_sw)   : fsm_we_q;
   assign mem_rd     = cpu_owns_q ? (cpu_rd & run_sw)   : fsm_rd_q;

   // Outside RUN+IDLE only an accepted step can tick the CPU; during a panel
   // sequence both terms are zero.
   assign cpu_ce_o   = (cpu_owns_q & run_sw) ? cpu_ce_in : step_ce_q;

   assign panel_addr = panel_addr_q;
   assign panel_data = panel_data_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;

endmodule

// File: tb/tb_panel_bus_ctrl.sv
// tb/tb_panel_bus_ctrl.sv - self-checking bench for panel_bus_ctrl

module tb_panel_bus_ctrl;

   localparam int AW = 16;
   localparam int DW = 8;
`ifdef PANEL_READBACK_EN
   localparam int DEP_LAT = 4;
   localparam int DEP_RD  = 1;
`else
   localparam int DEP_LAT = 2;
   localparam int DEP_RD  = 0;
`endif
   localparam int EXA_LAT = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          run_sw;
   logic          cpu_ce_in;
   logic          cpu_ce_o;
   logic          examine_i, examine_next_i, deposit_i, deposit_next_i, step_i;
   logic [AW-1:0] sw_addr;
   logic [DW-1:0] sw_data;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_we, cpu_rd;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we, mem_rd;
   logic [DW-1:0] mem_rdata;
   logic [AW-1:0] panel_addr;
   logic [DW-1:0] panel_data;
   logic          busy, done;

   always #5 clk = ~clk;

   panel_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset), .run_sw(run_sw),
      .cpu_ce_in(cpu_ce_in), .cpu_ce_o(cpu_ce_o),
      .examine_i(examine_i), .examine_next_i(examine_next_i),
      .deposit_i(deposit_i), .deposit_next_i(deposit_next_i), .step_i(step_i),
      .sw_addr(sw_addr), .sw_data(sw_data),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_rd(cpu_rd),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rd(mem_rd),
      .mem_rdata(mem_rdata),
      .panel_addr(panel_addr), .panel_data(panel_data),
      .busy(busy), .done(done)
   );

   // Memory environment: synchronous read, one-cycle latency, plus a
   // backdoor preload port used by the bench.
   logic [DW-1:0] mem_arr [0:65535];
   logic          pre_we;
   logic [AW-1:0] pre_addr;
   logic [DW-1:0] pre_data;

   always @(posedge clk) begin
      if (pre_we)      mem_arr[pre_addr] <= pre_data;
      else if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      mem_rdata <= mem_arr[mem_addr];
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: what the panel LEDs should show.
   logic [AW-1:0] ref_pa;
   logic [DW-1:0] ref_pd;

   // Results captured by run_cmd.
   int            r_lat, r_we, r_rd;
   logic [AW-1:0] r_addr1;
   logic [DW-1:0] r_wdata1;
   logic          r_we1, r_rd1, r_busy1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      pre_we   = 1'b1;
      pre_addr = a;
      pre_data = d;
      step();
      pre_we   = 1'b0;
   endtask

   // mask = {deposit_next, deposit, examine_next, examine, step}
   task automatic run_cmd(input logic [4:0] mask);
      {deposit_next_i, deposit_i, examine_next_i, examine_i, step_i} = mask;
      step();
      {deposit_next_i, deposit_i, examine_next_i, examine_i, step_i} = 5'b0;
      r_lat = -1; r_we = 0; r_rd = 0;
      r_addr1 = mem_addr; r_wdata1 = mem_wdata;
      r_we1 = mem_we; r_rd1 = mem_rd; r_busy1 = busy;
      for (int k = 1; k <= 12; k++) begin
         if (mem_we) r_we++;
         if (mem_rd) r_rd++;
         if (done) begin
            r_lat = k;
            break;
         end
         step();
      end
   endtask

   function automatic logic [4:0] cmd_mask(input int c);
      case (c)
         0: return 5'b00010;
         1: return 5'b00100;
         2: return 5'b01000;
         3: return 5'b10000;
         default: return 5'b00001;
      endcase
   endfunction

   initial begin
      logic [AW-1:0] tgt, prev_addr;
      logic [DW-1:0] v, exp_d;
      int            cmd, cnt, exp_lat, exp_we, exp_rd;

      reset = 1'b1; run_sw = 1'b0; cpu_ce_in = 1'b1;
      {deposit_next_i, deposit_i, examine_next_i, examine_i, step_i} = 5'b0;
      sw_addr = '0; sw_data = '0;
      cpu_addr = 16'hBEEF; cpu_wdata = 8'h99; cpu_we = 1'b1; cpu_rd = 1'b1;
      pre_we = 1'b0; pre_addr = '0; pre_data = '0;

      // Reset state
      step(); step(); step();
      check_val("rst_panel_addr", panel_addr, 0);
      check_val("rst_panel_data", panel_data, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_cpu_ce", cpu_ce_o, 0);
      check_val("rst_mem_we", mem_we, 0);
      check_val("rst_mem_rd", mem_rd, 0);
      check_val("rst_mem_addr", mem_addr, 0);
      check_val("rst_mem_wdata", mem_wdata, 0);
      cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_rd = 1'b0; cpu_ce_in = 1'b0;
      reset = 1'b0;
      step();
      ref_pa = '0; ref_pd = '0;

      // EXAMINE 0x1234
      preload(16'h1234, 8'hA5);
      sw_addr = 16'h1234;
      run_cmd(cmd_mask(0));
      check_val("ex_rd_t1", r_rd1, 1);
      check_val("ex_addr_t1", r_addr1, 16'h1234);
      check_val("ex_busy_t1", r_busy1, 1);
      check_val("ex_lat", r_lat, EXA_LAT);
      check_val("ex_pa", panel_addr, 16'h1234);
      check_val("ex_pd", panel_data, 8'hA5);
      check_val("ex_busy_done", busy, 0);

      // DEPOSIT NEXT 0x3C -> 0x1235, issued in the done cycle
      sw_data = 8'h3C;
      run_cmd(cmd_mask(3));
      check_val("dn_we_t1", r_we1, 1);
      check_val("dn_addr_t1", r_addr1, 16'h1235);
      check_val("dn_wdata_t1", r_wdata1, 8'h3C);
      check_val("dn_lat", r_lat, DEP_LAT);
      check_val("dn_we_cnt", r_we, 1);
      check_val("dn_pa", panel_addr, 16'h1235);
      check_val("dn_pd", panel_data, 8'h3C);
      check_val("dn_mem", mem_arr[16'h1235], 8'h3C);

      // EXAMINE NEXT wrap FFFF -> 0000
      preload(16'hFFFF, 8'h5A);
      preload(16'h0000, 8'h77);
      sw_addr = 16'hFFFF;
      run_cmd(cmd_mask(0));
      check_val("wrap_pre_pa", panel_addr, 16'hFFFF);
      run_cmd(cmd_mask(1));
      check_val("wrap_addr_t1", r_addr1, 16'h0000);
      check_val("wrap_pa", panel_addr, 16'h0000);
      check_val("wrap_pd", panel_data, 8'h77);
      ref_pa = 16'h0000;

      // deposit + examine together: deposit only
      sw_addr = 16'h4444; sw_data = 8'hC3;
      run_cmd(5'b01010);
      check_val("co_we_cnt", r_we, 1);
      check_val("co_rd_cnt", r_rd, DEP_RD);
      check_val("co_lat", r_lat, DEP_LAT);
      check_val("co_pa", panel_addr, ref_pa);
      check_val("co_mem", mem_arr[ref_pa], 8'hC3);

      // Pulses while busy are ignored
      preload(16'h0100, 8'h11);
      sw_addr = 16'h0100;
      examine_i = 1'b1;
      step();
      examine_i = 1'b1; deposit_i = 1'b1; sw_addr = 16'h0200;
      step();
      examine_i = 1'b0; deposit_i = 1'b0;
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         if (mem_we || busy && k >= 2) cnt++;
         step();
      end
      check_val("busy_ign_extra", cnt, 0);
      check_val("busy_ign_pa", panel_addr, 16'h0100);
      check_val("busy_ign_pd", panel_data, 8'h11);
      ref_pa = 16'h0100; ref_pd = 8'h11;

      // Randomized commands against the reference model
      for (int it = 0; it < 40; it++) begin
         cmd = $urandom_range(0, 4);
         sw_addr = AW'($urandom);
         sw_data = DW'($urandom);
         if (cmd == 4) begin
            cpu_ce_in = 1'b1;
            step_i = 1'b1;
            step();
            step_i = 1'b0;
            check_val("rnd_step_t1", cpu_ce_o, 1);
            cnt = 0;
            for (int k = 0; k < 4; k++) begin
               if (cpu_ce_o) cnt++;
               step();
            end
            check_val("rnd_step_cnt", cnt, 1);
            check_val("rnd_step_pa", panel_addr, ref_pa);
            cpu_ce_in = 1'b0;
            continue;
         end
         case (cmd)
            0: tgt = sw_addr;
            1: tgt = ref_pa + 16'd1;
            2: tgt = ref_pa;
            default: tgt = ref_pa + 16'd1;
         endcase
         if (cmd <= 1) begin
            v = DW'($urandom);
            preload(tgt, v);
            exp_d = v; exp_lat = EXA_LAT; exp_we = 0; exp_rd = 1;
         end else begin
            exp_d = sw_data; exp_lat = DEP_LAT; exp_we = 1; exp_rd = DEP_RD;
         end
         run_cmd(cmd_mask(cmd));
         check_val("rnd_lat", r_lat, exp_lat);
         check_val("rnd_we", r_we, exp_we);
         check_val("rnd_rd", r_rd, exp_rd);
         check_val("rnd_addr_t1", r_addr1, tgt);
         check_val("rnd_pa", panel_addr, tgt);
         check_val("rnd_pd", panel_data, exp_d);
         if (cmd >= 2) check_val("rnd_mem", mem_arr[tgt], sw_data);
         ref_pa = tgt; ref_pd = exp_d;
      end

      // RUN: clock-enable mirrors, panel pulses dropped, LEDs follow CPU
      run_sw = 1'b1;
      prev_addr = '0;
      for (int i = 0; i < 16; i++) begin
         cpu_ce_in = 1'($urandom);
         cpu_addr  = AW'($urandom);
         examine_i = 1'(i % 2);
         deposit_next_i = 1'(i % 3 == 0);
         #1;
         check_val("run_ce", cpu_ce_o, cpu_ce_in);
         check_val("run_mem_addr", mem_addr, cpu_addr);
         prev_addr = cpu_addr;
         step();
         check_val("run_busy", busy, 0);
         check_val("run_pa", panel_addr, prev_addr);
      end
      examine_i = 1'b0; deposit_next_i = 1'b0;

      // PAUSE: no CPU writes, no free-running ticks
      run_sw = 1'b0; cpu_we = 1'b1; cpu_ce_in = 1'b1;
      #1;
      check_val("pause_we", mem_we, 0);
      check_val("pause_ce", cpu_ce_o, 0);
      step();
      cpu_we = 1'b0;
      check_val("pause_pa_hold", panel_addr, prev_addr);

      // Reset during RA aborts the sequence
      sw_addr = 16'h2222;
      examine_i = 1'b1;
      step();
      examine_i = 1'b0;
      check_val("rra_in_ra", mem_rd, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_val("rra_busy", busy, 0);
      check_val("rra_pa", panel_addr, 0);
      check_val("rra_pd", panel_data, 0);
      check_val("rra_done", done, 0);
      step();
      check_val("rra_done2", done, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/panel_bus_ctrl.md
# panel_bus_ctrl

Front-panel sequencer and memory-bus arbiter for the Altair core. It sits between the 8080 core, the debounced front-panel pushbuttons and the memory/chip-select fabric. In RUN it passes the CPU bus through and gates the CPU clock-enable. In PAUSE it owns the bus and executes EXAMINE, EXAMINE NEXT, DEPOSIT, DEPOSIT NEXT and single-step as short fixed-length sequences.

## Interface
Parameters:
- `ADDR_W`, default 16: memory address width.
- `DATA_W`, default 8: data width.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: synchronous, active-high.
- `run_sw` in 1: 1 = RUN, 0 = PAUSE.
- `cpu_ce_in` in 1: free-running CPU clock-enable tick.
- `cpu_ce_o` out 1: gated CPU clock-enable.
- `examine_i`, `examine_next_i`, `deposit_i`, `deposit_next_i`, `step_i` in 1 each: one-cycle debounced press pulses.
- `sw_addr` in ADDR_W: address switches.
- `sw_data` in DATA_W: data switches.
- `cpu_addr` in ADDR_W, `cpu_wdata` in DATA_W, `cpu_we` in 1, `cpu_rd` in 1: CPU bus.
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W, `mem_we` out 1, `mem_rd` out 1: muxed bus to the memory decode.
- `mem_rdata` in DATA_W: synchronous memory read data, 1-cycle latency.
- `panel_addr` out ADDR_W, `panel_data` out DATA_W: LED values.
- `busy` out 1: panel sequence in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, WR, RA (read address), RD (read data).
- Reset: state IDLE. All outputs 0: `panel_addr`, `panel_data`, `busy`, `done`, `cpu_ce_o`, `mem_we`, `mem_rd`, `mem_addr`, `mem_wdata`.
- Bus mux:
  - state ≠ IDLE: FSM drives the `mem_*` outputs.
  - IDLE: CPU drives them, with `mem_we = cpu_we & run_sw` and `mem_rd = cpu_rd & run_sw`, so there are no stray writes in PAUSE.
- `cpu_ce_o`:
  - RUN and IDLE: `cpu_ce_in`.
  - PAUSE: a one-cycle pulse after an accepted `step_i`.
  - Any state ≠ IDLE: 0.
- Commands are accepted only in IDLE with `run_sw`=0. Otherwise they are dropped with no effect.
- Priority when pulses coincide: deposit_next > deposit > examine_next > examine > step.
- EXAMINE: target = `sw_addr`. Sequence IDLE→RA→RD→IDLE.
- EXAMINE NEXT: target = `panel_addr`+1, modulo 2^ADDR_W (FFFF→0000). Sequence IDLE→RA→RD→IDLE.
- DEPOSIT: target = `panel_addr`. Sequence IDLE→WR, then the readback path.
- DEPOSIT NEXT: target = `panel_addr`+1 (wraps). Sequence IDLE→WR, then the readback path.
- In WR: `mem_we`=1, `mem_wdata`=`sw_data`, `mem_addr`=target.
- In RA: `mem_rd`=1, `mem_addr`=target.
- In RD: `panel_data` ← `mem_rdata`.
- `panel_addr` ← target at the first cycle after acceptance.
- In RUN, while IDLE: `panel_addr` follows `cpu_addr` and `panel_data` follows `mem_rdata`, both registered.
- RUN→PAUSE while IDLE: the CPU freezes on its next tick and the bus is held unchanged.
- PAUSE→RUN mid-sequence: the sequence completes, then the bus is handed to the CPU. `cpu_ce_o` stays 0 until IDLE.
- `reset` asserted mid-sequence: abort to IDLE with reset values. A write issued in the same cycle is not guaranteed.

## Timing
- Command pulse sampled at cycle T.
- Examine / examine-next: RA at T+1, RD at T+2. `panel_data` valid and `done`=1 at T+3.
- Deposit with readback: WR at T+1, RA at T+2, RD at T+3. `done` at T+4.
- `busy`=1 exactly while state ≠ IDLE.
- Step: `cpu_ce_o`=1 at T+1 only.
- Back-to-back commands: the next command is accepted at the first IDLE cycle, i.e. the cycle in which `done` is high.

## Configuration
- `PANEL_READBACK_EN` defined: deposit follows WR→RA→RD, and `panel_data` shows the data read back from memory. This exposes writes to ROM regions.
- `PANEL_READBACK_EN` undefined: deposit is WR→IDLE. `panel_data` ← `sw_data` in WR, and `done` is asserted at T+2.

## Test plan
- Reset, PAUSE; preload mem[0x1234]=0xA5; `sw_addr`=0x1234; pulse `examine_i` at T. Expect `mem_rd` at T+1, then `panel_addr`=0x1234, `panel_data`=0xA5 and `done` at T+3.
- After the above, `sw_data`=0x3C; pulse `deposit_next_i`. Expect `mem_we` at addr 0x1235 with data 0x3C, `panel_addr`=0x1235, `panel_data`=0x3C. `done` at T+4 with the macro defined, T+2 without.
- `panel_addr`=0xFFFF; pulse `examine_next_i`. Expect `mem_addr`=0x0000 and `panel_addr`=0x0000.
- Pulse `deposit_i` and `examine_i` in the same cycle. Expect only the deposit: one write, no separate examine read. Any pulse during `busy` is ignored.
- RUN with `cpu_ce_in` toggling: `cpu_ce_o` mirrors it and panel pulses do nothing. PAUSE + `step_i`: exactly one `cpu_ce_o` pulse. `cpu_we`=1 in PAUSE gives `mem_we`=0.
- Assert `reset` during state RA. Next cycle: IDLE, `busy`=0, `panel_addr`=0, `panel_data`=0, no `done`.
